// File: rtl/ringclient.sv
// Parallel client adapter for a ring node: buffers user packets into ring words
// on a toggle handshake, and unpacks received ring words into a show-ahead FIFO.
module ringclient #(
  parameter  int WIDTH = 16,
  parameter  int ABITS = 3,
  parameter  int DEPTH = 4,
  localparam int PBITS = WIDTH - 2 - 2 * ABITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [ABITS-1:0] tx_dst,
  input  logic [PBITS-1:0] tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [ABITS-1:0] rx_src,
  output logic [PBITS-1:0] rx_data,
  output logic [WIDTH-1:0] fromclient,
  input  logic [WIDTH-1:0] toclient,
  input  logic             txready,
  output logic             mosivalid,
  input  logic             mosiack,
  input  logic             misovalid,
  output logic             misoack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ABITS + PBITS;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Full/empty use the pre-edge count, so a push into a full FIFO is refused
  // even when a pop happens on the same edge.
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                              input logic push, input logic pop);
    logic [CW-1:0] n;
    n = cnt;
    if (push && !pop) n = cnt + CNT_ONE;
    if (pop && !push) n = cnt - CNT_ONE;
    return n;
  endfunction

  logic [EW-1:0]    r_tx_mem [DEPTH];
  logic [PW-1:0]    r_tx_wp, r_tx_rp;
  logic [CW-1:0]    r_tx_cnt;
  logic [WIDTH-1:0] r_fromclient;
  logic             r_mosivalid;
  logic [EW-1:0]    w_tx_head;
  logic             w_tx_push, w_tx_issue;

  logic [EW-1:0]    r_rx_mem [DEPTH];
  logic [PW-1:0]    r_rx_wp, r_rx_rp;
  logic [CW-1:0]    r_rx_cnt;
  logic             r_misoack;
  logic [EW-1:0]    w_rx_head, w_rx_word;
  logic             w_rx_cap, w_rx_pop;
  logic             w_rx_unused;

  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_tx_push  = tx_valid && (r_tx_cnt < CNT_FULL);
  assign w_tx_issue = (r_tx_cnt != '0) && (mosiack == r_mosivalid) && txready;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= {tx_dst, tx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp      <= '0;
      r_tx_rp      <= '0;
      r_tx_cnt     <= '0;
      r_fromclient <= '0;
      r_mosivalid  <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
      if (w_tx_issue) begin
        r_tx_rp      <= r_tx_rp + PTR_ONE;
        r_fromclient <= {1'b1, 1'b0, w_tx_head[EW-1 -: ABITS], {ABITS{1'b0}},
                         w_tx_head[PBITS-1:0]};
        r_mosivalid  <= ~r_mosivalid;
      end
      r_tx_cnt <= next_cnt(r_tx_cnt, w_tx_push, w_tx_issue);
    end
  end

  assign w_rx_word   = {toclient[WIDTH-2-2*ABITS +: ABITS], toclient[PBITS-1:0]};
  assign w_rx_unused = ^toclient[WIDTH-1 -: 2 + ABITS];
  assign w_rx_cap    = (misovalid != r_misoack) && (r_rx_cnt < CNT_FULL);
  assign w_rx_pop    = rx_ready && (r_rx_cnt != '0);
  assign w_rx_head   = r_rx_mem[r_rx_rp];

  always_ff @(posedge clk) begin
    if (w_rx_cap) r_rx_mem[r_rx_wp] <= w_rx_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_misoack <= 1'b0;
    end else begin
      if (w_rx_cap) begin
        r_rx_wp   <= r_rx_wp + PTR_ONE;
        r_misoack <= ~r_misoack;
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + PTR_ONE;
      r_rx_cnt <= next_cnt(r_rx_cnt, w_rx_cap, w_rx_pop);
    end
  end

  assign tx_ready   = (r_tx_cnt < CNT_FULL);
  assign rx_valid   = (r_rx_cnt != '0);
  // Head is masked while empty so stale entries never reach the user side.
  assign rx_src     = rx_valid ? w_rx_head[EW-1 -: ABITS] : '0;
  assign rx_data    = rx_valid ? w_rx_head[PBITS-1:0] : '0;
  assign fromclient = r_fromclient;
  assign mosivalid  = r_mosivalid;
  assign misoack    = r_misoack;

endmodule

// File: tb/tb_ringclient.sv
// Directed bench for ringclient: send path, transmit backpressure, receive path,
// receive-full stall, simultaneous push/pop and mid-stream reset.
module tb_ringclient;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid, tx_ready;
  logic [2:0]  tx_dst;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [2:0]  rx_src;
  logic [7:0]  rx_data;
  logic [15:0] fromclient, toclient;
  logic        txready, mosivalid, mosiack, misovalid, misoack;

  int checks = 0;
  int errors = 0;
  logic mv, mi, ma;
  logic [10:0] q[$];
  logic [10:0] w;

  ringclient #(.WIDTH(16), .ABITS(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data),
    .fromclient(fromclient), .toclient(toclient), .txready(txready),
    .mosivalid(mosivalid), .mosiack(mosiack),
    .misovalid(misovalid), .misoack(misoack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] txw(input logic [2:0] d, input logic [7:0] p);
    return {2'b10, d, 3'b000, p};
  endfunction

  // FULL, ACK and DST set to ones to show they are ignored on receive.
  function automatic logic [15:0] rxw(input logic [2:0] s, input logic [7:0] p);
    return {2'b11, 3'b111, s, p};
  endfunction

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_dst = '0; tx_data = '0; rx_ready = 1'b0;
    toclient = '0; txready = 1'b0; mosiack = 1'b0; misovalid = 1'b0;
    mv = 1'b0; mi = 1'b0; ma = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_mosivalid", mosivalid, 0);
    chk("rst_misoack", misoack, 0);
    chk("rst_fromclient", fromclient, 0);

    // Single send
    txready = 1'b1; tx_valid = 1'b1; tx_dst = 3'd3; tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0;
    chk("send_not_yet", mosivalid, 0);
    tick();
    mv = 1'b1;
    chk("send_word", fromclient, 16'h98A5);
    chk("send_toggle", mosivalid, 1);
    mosiack = 1'b1;
    tick();
    chk("send_no_reissue", mosivalid, 1);

    // Transmit backpressure
    txready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_dst = 3'(i + 1); tx_data = 8'(8'h10 + i);
      chk("bp_tx_ready", tx_ready, (i < 4) ? 1 : 0);
      tick();
    end
    tx_valid = 1'b0;
    chk("bp_full", tx_ready, 0);
    txready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mv = ~mv;
      chk("bp_issue_toggle", mosivalid, mv);
      chk("bp_issue_word", fromclient, txw(3'(k + 1), 8'(8'h10 + k)));
      tick();
      chk("bp_hold_toggle", mosivalid, mv);
      chk("bp_hold_word", fromclient, txw(3'(k + 1), 8'(8'h10 + k)));
      mosiack = mv;
    end
    tick();
    chk("bp_fifth_dropped", mosivalid, mv);
    chk("bp_last_word", fromclient, txw(3'd4, 8'h13));
    chk("bp_ready_again", tx_ready, 1);

    // Receive
    toclient = rxw(3'd5, 8'h3C); mi = 1'b1; misovalid = mi;
    tick();
    ma = 1'b1;
    chk("rx_ack", misoack, ma);
    chk("rx_valid", rx_valid, 1);
    chk("rx_src", rx_src, 5);
    chk("rx_data", rx_data, 8'h3C);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_empty", rx_valid, 0);

    // Receive full
    for (int j = 0; j < 5; j++) begin
      toclient = rxw(3'(j + 1), 8'(8'h40 + j));
      mi = ~mi; misovalid = mi;
      tick();
      if (j < 4) ma = ~ma;
      chk("rxf_ack", misoack, ma);
    end
    tick();
    chk("rxf_stall", misoack, ma);
    chk("rxf_head0", {rx_src, rx_data}, {3'd1, 8'h40});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rxf_no_cap_on_pop", misoack, ma);
    chk("rxf_head1", {rx_src, rx_data}, {3'd2, 8'h41});
    tick();
    ma = ~ma;
    chk("rxf_late_cap", misoack, ma);
    for (int j = 1; j < 5; j++) begin
      chk("rxf_drain_valid", rx_valid, 1);
      chk("rxf_drain_head", {rx_src, rx_data}, {3'(j + 1), 8'(8'h40 + j)});
      rx_ready = 1'b1;
      tick();
    end
    rx_ready = 1'b0;
    chk("rxf_drained", rx_valid, 0);

    // Simultaneous push/pop at count 2
    for (int n = 0; n < 2; n++) begin
      w = {3'(n), 8'(8'h80 + n)};
      toclient = rxw(w[10:8], w[7:0]); mi = ~mi; misovalid = mi;
      q.push_back(w);
      tick();
      ma = ~ma;
    end
    for (int n = 2; n < 14; n++) begin
      w = {3'(n), 8'(8'h80 + n)};
      toclient = rxw(w[10:8], w[7:0]); mi = ~mi; misovalid = mi;
      rx_ready = 1'b1;
      chk("sim_head", {rx_src, rx_data}, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(w);
      ma = ~ma;
      chk("sim_ack", misoack, ma);
    end
    for (int n = 0; n < 2; n++) begin
      chk("sim_tail_valid", rx_valid, 1);
      chk("sim_tail_head", {rx_src, rx_data}, q.pop_front());
      tick();
    end
    rx_ready = 1'b0;
    chk("sim_count2", rx_valid, 0);

    // Mid-stream reset
    txready = 1'b0; tx_valid = 1'b1; tx_dst = 3'd7; tx_data = 8'h77;
    tick(); tick();
    tx_valid = 1'b0;
    toclient = rxw(3'd6, 8'h66); mi = ~mi; misovalid = mi;
    tick();
    chk("pre_rst_rx_valid", rx_valid, 1);
    #3;
    rst = 1'b1; mosiack = 1'b0; misovalid = 1'b0;
    #1;
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_mosivalid", mosivalid, 0);
    chk("mid_rst_misoack", misoack, 0);
    chk("mid_rst_fromclient", fromclient, 0);
    chk("mid_rst_rx_head", {rx_src, rx_data}, 0);
    tick(); tick();
    rst = 1'b0; txready = 1'b1;
    tick(); tick();
    chk("post_rst_tx_ready", tx_ready, 1);
    chk("post_rst_rx_valid", rx_valid, 0);
    chk("post_rst_no_issue", mosivalid, 0);
    chk("post_rst_fromclient", fromclient, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
